pc_unit: RTL and testbench

Parametrised program-counter unit for the pipeline fetch stage, replacing the single-register PC.
- Holds the fetch PC, gated by start and stall.
- Adds sequential increment, branch/call/return redirect, a trap vector with EPC capture, a halt state, and a small circular return-address stack (RAS).
- Feeds instruction memory and the IF/ID pipeline register.

---
 rtl/pc_pkg.sv | 18 +
 rtl/pc_ras.sv | 64 ++++++
 rtl/pc_unit.sv | 125 ++++++++++++
 tb/tb_pc_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch-stage program-counter unit.
package pc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0100;
    localparam int          DEF_INC      = 4;

    // Width of the circular return-stack pointer; never narrower than one bit.
    function automatic int ras_ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
module pc_ras
    import pc_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [PC_W-1:0] data_i,
    output logic [PC_W-1:0] top_o,
    output logic            empty_o,
    output logic            full_o
);

    localparam int PTR_W = ras_ptr_w(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    logic [PC_W-1:0]  mem_q [RAS_DEPTH];
    logic [PC_W-1:0]  mem_d [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] top_idx;

    // ptr_q names the next free slot; the top entry sits one below it.
    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push_i) begin
            mem_d[ptr_q] = data_i;
            ptr_d        = ptr_q + 1'b1;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (pop_i && (cnt_q != '0)) begin
            ptr_d = ptr_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    assign top_idx = ptr_q - 1'b1;
    assign top_o   = mem_q[top_idx];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_MAX);

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: IDLE/RUN/HALT control, trap vectoring with EPC
// capture, and branch/call/return redirect backed by a small return stack.
module pc_unit
    import pc_pkg::*;
#(
    parameter int          PC_W      = 32,
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter logic [31:0] TRAP_VEC  = DEF_TRAP_VEC,
    parameter int          INC       = DEF_INC,
    parameter int          RAS_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            halt_i,
    input  logic            pc_write_i,
    input  logic            branch_i,
    input  logic            call_i,
    input  logic            ret_i,
    input  logic [PC_W-1:0] target_i,
    input  logic            trap_i,
    output logic [PC_W-1:0] pc_o,
    output logic            pc_valid_o,
    output logic [PC_W-1:0] epc_o,
    output logic            ras_empty_o,
    output logic            ras_full_o,
    output logic            ras_underflow_o,
    output logic [1:0]      state_o
);

    localparam logic [PC_W-1:0] RST_PC  = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] TRAP_PC = PC_W'(TRAP_VEC);
    localparam logic [PC_W-1:0] STEP    = PC_W'(INC);

    pc_state_e       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] epc_q, epc_d;
    logic            uf_q, uf_d;
    logic            push, pop;
    logic [PC_W-1:0] pc_seq;
    logic [PC_W-1:0] ras_top;

    assign pc_seq = pc_q + STEP;

    pc_ras #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (pc_seq),
        .top_o   (ras_top),
        .empty_o (ras_empty_o),
        .full_o  (ras_full_o)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            pc_q    <= RST_PC;
            epc_q   <= '0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            uf_q    <= uf_d;
        end
    end

    // A trap keeps the unit in RUN even when halt_i is also raised.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_i) state_d = ST_RUN;
            ST_RUN:  if (halt_i && !trap_i) state_d = ST_HALT;
            ST_HALT: if (start_i) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pc_d  = pc_q;
        epc_d = epc_q;
        uf_d  = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        if (state_q == ST_IDLE) begin
            pc_d = RST_PC;
        end else if (state_q == ST_RUN) begin
            if (trap_i) begin
                epc_d = pc_q;
                pc_d  = TRAP_PC;
            end else if (halt_i || !pc_write_i) begin
                pc_d = pc_q;
            end else if (branch_i) begin
                pc_d = target_i;
            end else if (call_i) begin
                push = 1'b1;
                pc_d = target_i;
            end else if (ret_i) begin
                if (!ras_empty_o) begin
                    pop  = 1'b1;
                    pc_d = ras_top;
                end else begin
                    uf_d = 1'b1;
                    pc_d = target_i;
                end
            end else begin
                pc_d = pc_seq;
            end
        end
    end

    always_comb begin
        pc_o            = pc_q;
        epc_o           = epc_q;
        pc_valid_o      = (state_q == ST_RUN);
        ras_underflow_o = uf_q;
        state_o         = state_q;
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: sequencing, stall, call/return, RAS wrap, trap,
// PC wrap-around and halt/resume with hand-computed expected values.
module tb_pc_unit;

    localparam int PC_W = 32;

    logic            clk = 1'b0;
    logic            rst_i = 1'b0;
    logic            start_i = 1'b0;
    logic            halt_i = 1'b0;
    logic            pc_write_i = 1'b1;
    logic            branch_i = 1'b0;
    logic            call_i = 1'b0;
    logic            ret_i = 1'b0;
    logic [PC_W-1:0] target_i = '0;
    logic            trap_i = 1'b0;
    logic [PC_W-1:0] pc_o;
    logic            pc_valid_o;
    logic [PC_W-1:0] epc_o;
    logic            ras_empty_o;
    logic            ras_full_o;
    logic            ras_underflow_o;
    logic [1:0]      state_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pc_unit #(.PC_W(PC_W), .RAS_DEPTH(4)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .halt_i          (halt_i),
        .pc_write_i      (pc_write_i),
        .branch_i        (branch_i),
        .call_i          (call_i),
        .ret_i           (ret_i),
        .target_i        (target_i),
        .trap_i          (trap_i),
        .pc_o            (pc_o),
        .pc_valid_o      (pc_valid_o),
        .epc_o           (epc_o),
        .ras_empty_o     (ras_empty_o),
        .ras_full_o      (ras_full_o),
        .ras_underflow_o (ras_underflow_o),
        .state_o         (state_o)
    );

    // Inputs change on the falling edge; outputs are sampled on the next one.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_inputs();
        start_i = 0; halt_i = 0; pc_write_i = 1; branch_i = 0;
        call_i = 0; ret_i = 0; target_i = '0; trap_i = 0;
    endtask

    task automatic go_run();
        clear_inputs();
        rst_i = 0;
        tick(2);
        rst_i = 1;
        start_i = 1;
        tick(1);
        start_i = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        call_i = 1; start_i = 1; trap_i = 1;
        rst_i = 0;
        tick(2);
        n_checks++; if (pc_o !== 32'd0) begin n_errors++; $display("FAIL reset_pc got %0h want 0", pc_o); end
        n_checks++; if (pc_valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b want 0", pc_valid_o); end
        n_checks++; if (epc_o !== 32'd0) begin n_errors++; $display("FAIL reset_epc got %0h want 0", epc_o); end
        n_checks++; if ({ras_empty_o, ras_full_o, ras_underflow_o} !== 3'b100) begin n_errors++; $display("FAIL reset_flags got %b want 100", {ras_empty_o, ras_full_o, ras_underflow_o}); end
        clear_inputs();
        rst_i = 1;
        call_i = 1; target_i = 32'd64;
        tick(2);
        n_checks++; if ({pc_valid_o, pc_o} !== {1'b0, 32'd0}) begin n_errors++; $display("FAIL idle_ignores got v=%b pc=%0h want v=0 pc=0", pc_valid_o, pc_o); end
        n_checks++; if (ras_empty_o !== 1'b1) begin n_errors++; $display("FAIL idle_no_push got %b want 1", ras_empty_o); end
        clear_inputs();
    endtask

    task automatic test_start_seq();
        logic [PC_W-1:0] exp_pc [3];
        exp_pc[0] = 32'd4; exp_pc[1] = 32'd8; exp_pc[2] = 32'd12;
        go_run();
        n_checks++; if ({pc_valid_o, pc_o} !== {1'b1, 32'd0}) begin n_errors++; $display("FAIL start_first got v=%b pc=%0h want v=1 pc=0", pc_valid_o, pc_o); end
        for (int i = 0; i < 3; i++) begin
            tick(1);
            n_checks++; if (pc_o !== exp_pc[i]) begin n_errors++; $display("FAIL seq_%0d got %0h want %0h", i, pc_o, exp_pc[i]); end
        end
    endtask

    task automatic test_stall();
        go_run();
        tick(2);
        pc_write_i = 0; branch_i = 1; target_i = 32'd40;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            n_checks++; if (pc_o !== 32'd8) begin n_errors++; $display("FAIL stall_%0d got %0h want 8", i, pc_o); end
        end
        pc_write_i = 1; branch_i = 0;
        tick(1);
        n_checks++; if (pc_o !== 32'd12) begin n_errors++; $display("FAIL stall_release got %0h want c", pc_o); end
    endtask

    task automatic test_call_ret();
        go_run();
        tick(4);
        call_i = 1; target_i = 32'd100;
        tick(1);
        call_i = 0;
        n_checks++; if ({ras_empty_o, pc_o} !== {1'b0, 32'd100}) begin n_errors++; $display("FAIL call got e=%b pc=%0h want e=0 pc=64", ras_empty_o, pc_o); end
        tick(1);
        n_checks++; if (pc_o !== 32'd104) begin n_errors++; $display("FAIL call_seq got %0h want 68", pc_o); end
        ret_i = 1; target_i = 32'd200;
        tick(1);
        n_checks++; if ({ras_empty_o, ras_underflow_o, pc_o} !== {2'b10, 32'd20}) begin n_errors++; $display("FAIL ret got e=%b u=%b pc=%0h want e=1 u=0 pc=14", ras_empty_o, ras_underflow_o, pc_o); end
        tick(1);
        ret_i = 0;
        n_checks++; if ({ras_underflow_o, pc_o} !== {1'b1, 32'd200}) begin n_errors++; $display("FAIL ret_empty got u=%b pc=%0h want u=1 pc=c8", ras_underflow_o, pc_o); end
        tick(1);
        n_checks++; if ({ras_underflow_o, pc_o} !== {1'b0, 32'd204}) begin n_errors++; $display("FAIL uf_pulse got u=%b pc=%0h want u=0 pc=cc", ras_underflow_o, pc_o); end
    endtask

    task automatic test_ras_wrap();
        logic [PC_W-1:0] exp_ret [4];
        exp_ret[0] = 32'd404; exp_ret[1] = 32'd304; exp_ret[2] = 32'd204; exp_ret[3] = 32'd104;
        go_run();
        for (int i = 1; i <= 5; i++) begin
            call_i = 1; target_i = 32'(i * 100);
            tick(1);
        end
        call_i = 0;
        n_checks++; if ({ras_full_o, pc_o} !== {1'b1, 32'd500}) begin n_errors++; $display("FAIL ras_full got f=%b pc=%0h want f=1 pc=1f4", ras_full_o, pc_o); end
        ret_i = 1; target_i = 32'd700;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            n_checks++; if (pc_o !== exp_ret[i]) begin n_errors++; $display("FAIL ras_pop_%0d got %0h want %0h", i, pc_o, exp_ret[i]); end
        end
        n_checks++; if ({ras_empty_o, ras_full_o} !== 2'b10) begin n_errors++; $display("FAIL ras_drained got e=%b f=%b want e=1 f=0", ras_empty_o, ras_full_o); end
        tick(1);
        ret_i = 0;
        n_checks++; if ({ras_underflow_o, pc_o} !== {1'b1, 32'd700}) begin n_errors++; $display("FAIL ras_fifth got u=%b pc=%0h want u=1 pc=2bc", ras_underflow_o, pc_o); end
    endtask

    task automatic test_back_to_back();
        go_run();
        branch_i = 1; call_i = 1; ret_i = 1; target_i = 32'd80;
        tick(1);
        clear_inputs();
        n_checks++; if ({ras_empty_o, pc_o} !== {1'b1, 32'd80}) begin n_errors++; $display("FAIL prio_branch got e=%b pc=%0h want e=1 pc=50", ras_empty_o, pc_o); end
        call_i = 1; ret_i = 1; target_i = 32'd160;
        tick(1);
        clear_inputs();
        n_checks++; if ({ras_empty_o, pc_o} !== {1'b0, 32'd160}) begin n_errors++; $display("FAIL prio_call got e=%b pc=%0h want e=0 pc=a0", ras_empty_o, pc_o); end
    endtask

    task automatic test_trap();
        go_run();
        tick(12);
        trap_i = 1; pc_write_i = 0; halt_i = 1;
        tick(1);
        n_checks++; if ({pc_valid_o, pc_o, epc_o} !== {1'b1, 32'h100, 32'd48}) begin n_errors++; $display("FAIL trap got v=%b pc=%0h epc=%0h want v=1 pc=100 epc=30", pc_valid_o, pc_o, epc_o); end
        rst_i = 0;
        tick(1);
        n_checks++; if ({pc_valid_o, pc_o, epc_o} !== {1'b0, 32'd0, 32'd0}) begin n_errors++; $display("FAIL trap_reset got v=%b pc=%0h epc=%0h want v=0 pc=0 epc=0", pc_valid_o, pc_o, epc_o); end
        rst_i = 1;
        clear_inputs();
    endtask

    task automatic test_wrap_halt();
        go_run();
        branch_i = 1; target_i = 32'hFFFF_FFFC;
        tick(1);
        branch_i = 0;
        tick(1);
        n_checks++; if (pc_o !== 32'd0) begin n_errors++; $display("FAIL pc_wrap got %0h want 0", pc_o); end
        tick(1);
        halt_i = 1;
        tick(1);
        halt_i = 0;
        trap_i = 1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if ({pc_valid_o, pc_o, epc_o} !== {1'b0, 32'd4, 32'd0}) begin n_errors++; $display("FAIL halt_%0d got v=%b pc=%0h epc=%0h want v=0 pc=4 epc=0", i, pc_valid_o, pc_o, epc_o); end
            tick(1);
        end
        trap_i = 0;
        start_i = 1;
        tick(1);
        start_i = 0;
        n_checks++; if ({pc_valid_o, pc_o} !== {1'b1, 32'd4}) begin n_errors++; $display("FAIL resume got v=%b pc=%0h want v=1 pc=4", pc_valid_o, pc_o); end
        tick(1);
        n_checks++; if (pc_o !== 32'd8) begin n_errors++; $display("FAIL resume_seq got %0h want 8", pc_o); end
    endtask

    initial begin
        tick(1);
        test_reset();
        test_start_seq();
        test_stall();
        test_call_ret();
        test_ras_wrap();
        test_back_to_back();
        test_trap();
        test_wrap_halt();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
